// File: rtl/uart_tx_arb_pkg.sv
// Shared types and width helpers for the UART TX round-robin burst arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Index width; a single-bit index is kept even for degenerate sizes
  function automatic int owner_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  // Burst counter must be able to hold MAX_BURST itself
  function automatic int bcnt_w(input int mb);
    return $clog2(mb + 32'sd1);
  endfunction

  localparam int OWNER_W = owner_w(32'sd4);
  localparam int BCNT_W  = bcnt_w(32'sd16);

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OW    = OWNER_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [OW-1:0]    idx,
  output logic             any_req
);

  // Scan upward from ptr; the first set request wins
  always_comb begin
    int j;
    j       = 32'sd0;
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 32'sd0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any_req && req[j]) begin
        gnt[j]  = 1'b1;
        idx     = OW'(j);
        any_req = 1'b1;
      end else begin
        any_req = any_req;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Burst-locking round-robin arbiter for the shared UART TX write port.
// Optional stall watchdog enabled by defining UART_TX_ARB_WDOG_EN.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
`ifdef UART_TX_ARB_WDOG_EN
  parameter int WDOG_CYC  = 1024,
`endif
  localparam int OW = owner_w(N_REQ),
  localparam int BW = bcnt_w(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  last,
  input  logic [N_REQ*DW-1:0] data,
  output logic [N_REQ-1:0]  ack,
  input  logic              tx_full,
  output logic              tx_write,
  output logic [DW-1:0]     tx_data,
  output logic              busy,
  output logic [OW-1:0]     owner
`ifdef UART_TX_ARB_WDOG_EN
  ,
  output logic              wdog_err
`endif
);

  state_t            state_r, state_nxt_s;
  logic [OW-1:0]     owner_r, ptr_r, pick_idx_s, ptr_nxt_s;
  logic [N_REQ-1:0]  own_oh_r, pick_gnt_s;
  logic [BW-1:0]     cnt_r, cnt_inc_s;
  logic [DW-1:0]     data_own_s, tx_data_r;
  logic              any_req_s, req_own_s, last_own_s, burst_end_s;
  logic              accept_s, release_s, arb_s, wdog_hit_s;
  logic              tx_write_r, busy_r;

  rr_pick #(.N_REQ(N_REQ), .OW(OW)) u_pick (
    .req     (req),
    .ptr     (ptr_r),
    .gnt     (pick_gnt_s),
    .idx     (pick_idx_s),
    .any_req (any_req_s)
  );

  // Owner lane selection through the registered one-hot grant
  always_comb begin
    req_own_s  = |(req & own_oh_r);
    last_own_s = |(last & own_oh_r);
    data_own_s = '0;
    for (int i = 32'sd0; i < N_REQ; i++) begin
      data_own_s = data_own_s | (data[i*DW +: DW] & {DW{own_oh_r[i]}});
    end
  end

  assign cnt_inc_s   = cnt_r + BW'(1);
  assign burst_end_s = (cnt_inc_s == BW'(MAX_BURST));
  assign ptr_nxt_s   = (owner_r == OW'(N_REQ - 32'sd1)) ? '0 : owner_r + OW'(1);

`ifdef UART_TX_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 32'sd1);
  logic [WW-1:0] wdog_cnt_r;
  logic          stall_s, wdog_err_r;

  assign stall_s    = (state_r == LOCK) && req_own_s && tx_full;
  assign wdog_hit_s = stall_s && (wdog_cnt_r == WW'(WDOG_CYC - 32'sd1));

  // Stall watchdog; any non-stalled cycle (including an accept) clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_r <= '0;
      wdog_err_r <= 1'b0;
    end else begin
      wdog_cnt_r <= (stall_s && !wdog_hit_s) ? wdog_cnt_r + WW'(1) : '0;
      wdog_err_r <= wdog_hit_s;
    end
  end

  assign wdog_err = wdog_err_r;
`else
  assign wdog_hit_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_nxt_s = LOCK;
        else           state_nxt_s = IDLE;
      end
      LOCK: begin
        if (release_s) state_nxt_s = IDLE;
        else           state_nxt_s = LOCK;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: no byte is taken in the arbitration cycle
  always_comb begin
    accept_s  = 1'b0;
    release_s = 1'b0;
    arb_s     = 1'b0;
    ack       = '0;
    case (state_r)
      IDLE: begin
        arb_s = any_req_s;
      end
      LOCK: begin
        accept_s  = req_own_s & ~tx_full;
        release_s = (accept_s & (last_own_s | burst_end_s)) | ~req_own_s | wdog_hit_s;
        if (accept_s) ack = own_oh_r;
        else          ack = '0;
      end
      default: begin
        arb_s = 1'b0;
      end
    endcase
  end

  // Grant bookkeeping and registered TX write path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r    <= '0;
      own_oh_r   <= '0;
      ptr_r      <= '0;
      cnt_r      <= '0;
      tx_write_r <= 1'b0;
      tx_data_r  <= '0;
      busy_r     <= 1'b0;
    end else begin
      tx_write_r <= accept_s;
      busy_r     <= (state_nxt_s == LOCK);
      if (accept_s) tx_data_r <= data_own_s;
      if (arb_s) begin
        owner_r  <= pick_idx_s;
        own_oh_r <= pick_gnt_s;
        cnt_r    <= '0;
      end else if (accept_s) begin
        cnt_r    <= cnt_inc_s;
      end
      if (release_s) ptr_r <= ptr_nxt_s;
    end
  end

  assign tx_write = tx_write_r;
  assign tx_data  = tx_data_r;
  assign busy     = busy_r;
  assign owner    = owner_r;

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin, burst-locking arbiter that shares the single UART TX write port among N_REQ requesters.
- It sits upstream of the TX enable gate and drives its tx_write/tx_data pair.
- A requester that wins arbitration keeps the port until its burst ends, so multi-byte messages are never interleaved.
- It back-pressures on TX FIFO full.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, data width per byte
MAX_BURST, 16, max bytes per grant before forced release (1..255)
WDOG_CYC, 1024, watchdog timeout in cycles (used only with UART_TX_ARB_WDOG_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester byte-valid; held with data until ack
last  in  N_REQ  per-requester end-of-burst marker, qualified by req
data  in  N_REQ*DW  packed requester bytes; requester i uses bits [i*DW +: DW]
ack  out  N_REQ  combinational one-hot; byte of owner accepted this cycle
tx_full  in  1  TX FIFO full
tx_write  out  1  registered write strobe to TX path
tx_data  out  DW  registered write data
busy  out  1  high while a grant is held
owner  out  clog2(N_REQ)  index of current grantee, valid when busy
wdog_err  out  1  one-cycle timeout pulse (only with UART_TX_ARB_WDOG_EN)

Behaviour:
- Reset values: tx_write=0, tx_data=0, busy=0, owner=0, ack=0, rr pointer=0, burst count=0, state=IDLE, wdog_err=0.
- States: IDLE, LOCK.
- IDLE:
  - If any req is high, pick the first requester at or after the rr pointer, wrapping modulo N_REQ.
  - Load owner, clear the burst count, go to LOCK next cycle.
  - No byte is accepted in the arbitration cycle.
- LOCK, accept:
  - Accept when req[owner] && !tx_full. ack[owner]=1 that cycle.
  - Next cycle: tx_write=1 and tx_data=data[owner]. Latency is 1 cycle.
  - Burst count increments on each accept.
- LOCK, release to IDLE after any of:
  - an accepted byte with last[owner]=1;
  - an accepted byte that makes the burst count equal MAX_BURST;
  - req[owner] low while in LOCK (abandoned burst).
  - On release, rr pointer is set to owner+1 mod N_REQ. busy falls the cycle after release.
- Arbitration gap: at least one cycle between bursts, even when the same requester re-requests.
- tx_full high: no ack, no tx_write. Owner is retained indefinitely, except under the watchdog.
- Simultaneous last and MAX_BURST on the same byte: a single release; the pointer advances once.
- Non-owner req/last are ignored while in LOCK.
- tx_write is never high in two cycles unless two consecutive accepts occurred. There are no bubbles inside a burst when req is held and tx_full is low.
- rst_n asserted mid-burst: immediate return to reset values. The partial burst is dropped, and no tx_write is issued after reset.

Optional Feature:
UART_TX_ARB_WDOG_EN
- Defined:
  - A counter runs while in LOCK with req[owner]=1 and tx_full=1; it clears on any accept.
  - On reaching WDOG_CYC: wdog_err pulses for 1 cycle, forced release to IDLE, rr pointer advances.
- Undefined: no counter and no wdog_err port. Stalls hold the grant forever.

Decomposition:
- Package uart_tx_arb_pkg:
  - state enum (IDLE, LOCK);
  - localparams for owner width clog2(N_REQ) and burst-count width clog2(MAX_BURST+1).
- One sub-module, rr_pick:
  - combinational round-robin picker;
  - inputs: req vector and pointer;
  - outputs: one-hot grant, index, any_req.

Test Plan:
- Reset/idle: rst_n low then high, no req -> all outputs 0, busy stays 0 for 20 cycles.
- Single burst: req0 sends 0x41,0x42,0x43 with last on 0x43, tx_full=0 -> arbitration cycle, three acks on consecutive cycles, tx_write/tx_data sequence 41,42,43 each one cycle after its ack, busy falls, pointer=1.
- Round-robin: req0..req3 all high with 1-byte bursts (last=1) from pointer 0 -> grant order 0,1,2,3,0, each separated by one arbitration cycle.
- Forced release: req2 streams 20 bytes with no last, MAX_BURST=16 -> exactly 16 tx_writes, release, req2 re-arbitrates only after the other pending requesters are served.
- Back-pressure: tx_full high for 5 cycles mid-burst -> no ack and no tx_write during those cycles, owner unchanged, burst resumes with the same byte; with UART_TX_ARB_WDOG_EN and WDOG_CYC=8, tx_full held for 8 cycles -> wdog_err pulse and release.
- Reset mid-burst: rst_n low after 2 of 4 bytes -> tx_write=0 immediately, busy=0, pointer=0, no further writes after deassert until new req.
